// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-client scratch-memory arbiter.
package mem_arb_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_ADDR_W    = 5;
  localparam int DEF_MEM_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  typedef struct packed {
    logic                  write;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } req_t;

  // True when a word address falls beyond the implemented memory.
  function automatic logic addrOutOfRange(input int addr, input int depth);
    return addr >= depth;
  endfunction

endpackage

// File: rtl/mem_arb_if.sv
// One requester channel: valid/ready request plus single-cycle response.
interface mem_arb_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic              valid;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              rspValid;
  logic [DATA_W-1:0] rspRdata;
  logic              rspErr;

  modport master (
    output valid, write, addr, wdata,
    input  ready, rspValid, rspRdata, rspErr
  );

  modport slave (
    input  valid, write, addr, wdata,
    output ready, rspValid, rspRdata, rspErr
  );
endinterface

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker: the requester that did not win last time
// gets priority under contention; a lone requester always wins.
module mem_arb_rr (
  input  logic [1:0] valid,
  input  logic       lastGrant,
  input  logic       accept,
  output logic       pickId,
  output logic       anyValid,
  output logic       nextGrant
);

  // Pick a requester and compute the grant history for the next cycle.
  always_comb begin
    anyValid = |valid;
    if (&valid) begin
      pickId = ~lastGrant;
    end else begin
      pickId = valid[1];
    end
    nextGrant = accept ? pickId : lastGrant;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin owner of the scratch memory port: accepts one request,
// drives the memory for one cycle, then returns a one-cycle response.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_arb_if.slave          req0,
  mem_arb_if.slave          req1,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state;
  state_t            stateNext;
  logic              lastGrant;
  logic              nextGrant;
  logic              pickId;
  logic              anyValid;
  logic              accept;
  logic              pickWrite;
  logic [ADDR_W-1:0] pickAddr;
  logic [DATA_W-1:0] pickWdata;
  logic              latWrite;
  logic              latId;
  logic              latOor;
  logic [ADDR_W-1:0] latAddr;
  logic [DATA_W-1:0] latWdata;
  logic              capture;
  logic [DATA_W-1:0] rspData;

  mem_arb_rr uRr (
    .valid     ({req1.valid, req0.valid}),
    .lastGrant (lastGrant),
    .accept    (accept),
    .pickId    (pickId),
    .anyValid  (anyValid),
    .nextGrant (nextGrant)
  );

  // Acceptance strobe and the picked requester's request fields.
  always_comb begin
    accept    = rst_n && (state == IDLE) && anyValid;
    pickWrite = pickId ? req1.write : req0.write;
    pickAddr  = pickId ? req1.addr  : req0.addr;
    pickWdata = pickId ? req1.wdata : req0.wdata;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next state: one accepted access walks IDLE -> ISSUE -> CAPTURE -> IDLE.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (accept) stateNext = ISSUE;
      ISSUE:   stateNext = CAPTURE;
      CAPTURE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Grant history; starts at 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lastGrant <= 1'b1;
    end else begin
      lastGrant <= nextGrant;
    end
  end

  // Request latches, captured on the acceptance edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latWrite <= 1'b0;
      latId    <= 1'b0;
      latOor   <= 1'b0;
      latAddr  <= '0;
      latWdata <= '0;
    end else if (accept) begin
      latWrite <= pickWrite;
      latId    <= pickId;
      latOor   <= addrOutOfRange(int'(pickAddr), MEM_DEPTH);
      latAddr  <= pickAddr;
      latWdata <= pickWdata;
    end
  end

  // Outputs: ready in IDLE, memory drive in ISSUE, response in CAPTURE.
  always_comb begin
    req0.ready = accept && !pickId;
    req1.ready = accept &&  pickId;

    mem_addr  = latAddr;
    mem_wdata = latWdata;
    mem_we    = (state == ISSUE) && latWrite && !latOor;

    capture = (state == CAPTURE);
    rspData = latOor ? '0 : mem_rdata;

    req0.rspValid = capture && !latId;
    req0.rspErr   = capture && !latId && latOor;
    req0.rspRdata = (capture && !latId) ? rspData : '0;
    req1.rspValid = capture &&  latId;
    req1.rspErr   = capture &&  latId && latOor;
    req1.rspRdata = (capture &&  latId) ? rspData : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, checked
// cycle by cycle against a transaction-level model of the arbiter.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arb_if #(.DATA_W(DW), .ADDR_W(AW)) req0 ();
  mem_arb_if #(.DATA_W(DW), .ADDR_W(AW)) req1 ();

  logic [DW-1:0] mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .mem_wdata (mem_wdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  // Scratch memory: 16x8, registered read, written data shows on rdata.
  logic [DW-1:0] memArr [DEPTH];
  bit memReady = 1'b0;
  always @(posedge clk) begin
    if (!memReady) begin
      for (int i = 0; i < DEPTH; i++) memArr[i] <= 8'(i * 37 + 5);
      memReady <= 1'b1;
    end else if (mem_we) begin
      memArr[mem_addr[3:0]] <= mem_wdata;
      mem_rdata <= mem_wdata;
    end else begin
      mem_rdata <= memArr[mem_addr[3:0]];
    end
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Transaction-level model state.
  logic [DW-1:0] refMem [DEPTH];
  int      busy;       // cycles left until the port is free again (2,1,0)
  bit      lastG;
  bit      rspId;
  logic [DW-1:0] rspData;
  bit      rspErr;
  bit      issueWe;
  logic [AW-1:0] issueAddr;
  logic [DW-1:0] issueData;

  req_t q0 [$];
  req_t q1 [$];
  req_t cur [2];
  bit   curV [2];
  bit   gaps;

  task automatic drive();
    req0.valid = curV[0];
    req0.write = cur[0].write;
    req0.addr  = cur[0].addr;
    req0.wdata = cur[0].wdata;
    req1.valid = curV[1];
    req1.write = cur[1].write;
    req1.addr  = cur[1].addr;
    req1.wdata = cur[1].wdata;
  endtask

  task automatic refill();
    if (gaps && curV[0] && $urandom_range(0, 7) == 0) curV[0] = 1'b0;
    if (gaps && curV[1] && $urandom_range(0, 7) == 0) curV[1] = 1'b0;
    if (!curV[0] && q0.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
      cur[0] = q0.pop_front();
      curV[0] = 1'b1;
    end
    if (!curV[1] && q1.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
      cur[1] = q1.pop_front();
      curV[1] = 1'b1;
    end
  endtask

  // One clock: check mid-cycle against the model, then advance the model.
  task automatic step();
    bit exp0, exp1, pick, n;
    req_t r;
    @(negedge clk);
    exp0 = 1'b0;
    exp1 = 1'b0;
    if (busy == 0 && (curV[0] || curV[1])) begin
      pick = (curV[0] && curV[1]) ? ~lastG : curV[1];
      exp0 = !pick;
      exp1 = pick;
    end
    check("ready0", 32'(req0.ready), 32'(exp0));
    check("ready1", 32'(req1.ready), 32'(exp1));
    check("rsp0_valid", 32'(req0.rspValid), 32'(busy == 1 && !rspId));
    check("rsp1_valid", 32'(req1.rspValid), 32'(busy == 1 && rspId));
    check("rsp0_rdata", 32'(req0.rspRdata), (busy == 1 && !rspId) ? 32'(rspData) : 32'd0);
    check("rsp1_rdata", 32'(req1.rspRdata), (busy == 1 && rspId) ? 32'(rspData) : 32'd0);
    check("rsp0_err", 32'(req0.rspErr), 32'(busy == 1 && !rspId && rspErr));
    check("rsp1_err", 32'(req1.rspErr), 32'(busy == 1 && rspId && rspErr));
    check("mem_we", 32'(mem_we), 32'(busy == 2 && issueWe));
    if (busy == 2) begin
      check("mem_addr", 32'(mem_addr), 32'(issueAddr));
      check("mem_wdata", 32'(mem_wdata), 32'(issueData));
    end
    @(posedge clk);
    if (busy > 0) busy--;
    if (exp0 || exp1) begin
      n = exp1;
      r = cur[n];
      lastG = n;
      rspId = n;
      issueAddr = r.addr;
      issueData = r.wdata;
      if (r.addr >= DEPTH) begin
        rspData = '0;
        rspErr  = 1'b1;
        issueWe = 1'b0;
      end else if (r.write) begin
        refMem[r.addr[3:0]] = r.wdata;
        rspData = r.wdata;
        rspErr  = 1'b0;
        issueWe = 1'b1;
      end else begin
        rspData = refMem[r.addr[3:0]];
        rspErr  = 1'b0;
        issueWe = 1'b0;
      end
      busy = 2;
      curV[n] = 1'b0;
    end
    #1;
    refill();
    drive();
  endtask

  task automatic runUntilIdle(input int maxCycles);
    int i = 0;
    bit idle;
    while ((q0.size() > 0 || q1.size() > 0 || curV[0] || curV[1] || busy != 0) && i < maxCycles) begin
      step();
      i++;
    end
    idle = (q0.size() == 0 && q1.size() == 0 && !curV[0] && !curV[1] && busy == 0);
    check("drained", 32'(idle), 32'd1);
  endtask

  task automatic checkAllReset(input string pfx);
    check({pfx, "_ready0"}, 32'(req0.ready), 32'd0);
    check({pfx, "_ready1"}, 32'(req1.ready), 32'd0);
    check({pfx, "_rsp0_valid"}, 32'(req0.rspValid), 32'd0);
    check({pfx, "_rsp1_valid"}, 32'(req1.rspValid), 32'd0);
    check({pfx, "_rsp0_rdata"}, 32'(req0.rspRdata), 32'd0);
    check({pfx, "_rsp1_rdata"}, 32'(req1.rspRdata), 32'd0);
    check({pfx, "_rsp0_err"}, 32'(req0.rspErr), 32'd0);
    check({pfx, "_rsp1_err"}, 32'(req1.rspErr), 32'd0);
    check({pfx, "_mem_we"}, 32'(mem_we), 32'd0);
    check({pfx, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({pfx, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waitCyc;
    for (int i = 0; i < DEPTH; i++) refMem[i] = 8'(i * 37 + 5);
    busy = 0;
    lastG = 1'b1;
    rspId = 1'b0;
    rspData = '0;
    rspErr = 1'b0;
    issueWe = 1'b0;
    issueAddr = '0;
    issueData = '0;
    gaps = 1'b0;
    curV[0] = 1'b0;
    curV[1] = 1'b0;
    cur[0] = '0;
    cur[1] = '0;

    // Reset state, with a write already waiting on requester 0.
    q0.push_back('{write: 1'b1, addr: 5'd3, wdata: 8'hA5});
    refill();
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkAllReset("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Write then read the same word from the other requester.
    runUntilIdle(20);
    q1.push_back('{write: 1'b0, addr: 5'd3, wdata: 8'h00});
    runUntilIdle(20);

    // Contention: both requesters stream reads of addresses 1 and 2.
    for (int i = 0; i < 4; i++) begin
      q0.push_back('{write: 1'b0, addr: 5'd1, wdata: 8'(i)});
      q1.push_back('{write: 1'b0, addr: 5'd2, wdata: 8'(i)});
    end
    refill();
    drive();
    runUntilIdle(60);

    // Out-of-range write, then read of the aliased in-range word.
    q1.push_back('{write: 1'b1, addr: 5'd20, wdata: 8'h3C});
    runUntilIdle(20);
    q0.push_back('{write: 1'b0, addr: 5'd4, wdata: 8'h00});
    runUntilIdle(20);

    // Single requester back-to-back reads.
    for (int i = 0; i < 4; i++)
      q0.push_back('{write: 1'b0, addr: 5'($urandom_range(0, 15)), wdata: 8'h00});
    runUntilIdle(40);

    // Reset during ISSUE of a write.
    q0.push_back('{write: 1'b1, addr: 5'd7, wdata: 8'h5A});
    waitCyc = 0;
    while (busy != 2 && waitCyc < 10) begin
      step();
      waitCyc++;
    end
    check("reached_issue", 32'(busy), 32'd2);
    check("issue_we", 32'(mem_we), 32'(issueWe));
    #1 rst_n = 1'b0;
    #1;
    checkAllReset("midrst");
    busy = 0;
    lastG = 1'b1;
    cur[0] = '{write: 1'b0, addr: 5'd2, wdata: 8'h00};
    cur[1] = '{write: 1'b0, addr: 5'd3, wdata: 8'h00};
    curV[0] = 1'b1;
    curV[1] = 1'b1;
    drive();
    @(negedge clk);
    checkAllReset("inrst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    // The interrupted write may or may not have landed; follow the memory.
    refMem[7] = memArr[7];
    runUntilIdle(30);

    // Random traffic with gaps and dropped requests.
    gaps = 1'b1;
    for (int i = 0; i < 40; i++) begin
      q0.push_back('{write: 1'($urandom_range(0, 1)), addr: 5'($urandom_range(0, 19)),
                     wdata: 8'($urandom)});
      q1.push_back('{write: 1'($urandom_range(0, 1)), addr: 5'($urandom_range(0, 19)),
                     wdata: 8'($urandom)});
    end
    runUntilIdle(2000);
    gaps = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
